// File: rtl/instr_fetch_queue.sv
// First-word-fall-through queue of fetched instruction words with their PCs.
// The head entry is decoded combinationally into MIPS fields for the control FSM.
module instr_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned EXT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [PC_WIDTH-1:0]          in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [5:0]                   opcode,
  output logic [4:0]                   rs,
  output logic [4:0]                   rt,
  output logic [4:0]                   rd,
  output logic [4:0]                   shamt,
  output logic [5:0]                   funct,
  output logic [15:0]                  imm16,
  output logic [EXT_WIDTH-1:0]         imm_ext,
  output logic [25:0]                  target,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [31:0]         r_instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] r_pc_mem    [DEPTH];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]     r_count;

  logic                w_push;
  logic                w_pop;
  logic [PtrW-1:0]     w_wr_ptr_inc;
  logic [PtrW-1:0]     w_rd_ptr_inc;
  logic [31:0]         w_head_instr;
  logic [PC_WIDTH-1:0] w_head_pc;
  logic                w_zero_ext;
  logic                w_sign;

  // A full queue refuses pushes even when popping: no pass-through path.
  assign in_ready  = (r_count < CntW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  // Explicit wrap so non-power-of-two depths work.
  assign w_wr_ptr_inc = (r_wr_ptr == PtrW'(DEPTH - 1)) ? '0 : r_wr_ptr + PtrW'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PtrW'(DEPTH - 1)) ? '0 : r_rd_ptr + PtrW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is intentionally not reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= in_instr;
      r_pc_mem[r_wr_ptr]    <= in_pc;
    end
  end

  assign w_head_instr = out_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign w_head_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : '0;

  assign out_instr = w_head_instr;
  assign out_pc    = w_head_pc;
  assign opcode    = w_head_instr[31:26];
  assign rs        = w_head_instr[25:21];
  assign rt        = w_head_instr[20:16];
  assign rd        = w_head_instr[15:11];
  assign shamt     = w_head_instr[10:6];
  assign funct     = w_head_instr[5:0];
  assign imm16     = w_head_instr[15:0];
  assign target    = w_head_instr[25:0];

  // andi / ori / xori take a zero-extended immediate; everything else sign-extends.
  assign w_zero_ext = (w_head_instr[31:26] == 6'h0C) || (w_head_instr[31:26] == 6'h0D) ||
                      (w_head_instr[31:26] == 6'h0E);
  assign w_sign     = w_head_instr[15] && !w_zero_ext;

  always_comb begin
    imm_ext       = {EXT_WIDTH{w_sign}};
    imm_ext[15:0] = w_head_instr[15:0];
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a count/queue reference model records accepted
// words, and a negedge monitor checks handshake signals and the decoded head entry.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] imm_ext;
  logic [25:0] target;
  logic [2:0]  count;

  instr_fetch_queue #(
    .DEPTH(DEPTH),
    .PC_WIDTH(32),
    .EXT_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .in_pc(in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .opcode(opcode),
    .rs(rs),
    .rt(rt),
    .rd(rd),
    .shamt(shamt),
    .funct(funct),
    .imm16(imm16),
    .imm_ext(imm_ext),
    .target(target),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;

  // Expected output order: {pc, instr} of every accepted word not yet consumed.
  logic [63:0] exp_q[$];
  int          mdl_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: acceptance decided from the occupancy before the edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        mdl_cnt = 0;
        exp_q.delete();
      end else begin
        if (out_ready && mdl_cnt > 0) mdl_cnt = mdl_cnt - 1;
        if (in_valid && (mdl_cnt + (out_ready && exp_q.size() > 0 ? 1 : 0)) < DEPTH) begin
          mdl_cnt = mdl_cnt + 1;
          exp_q.push_back({in_pc, in_instr});
        end
      end
    end
  end

  always @(negedge rst_n) begin
    mdl_cnt = 0;
    exp_q.delete();
  end

  // Monitor: compare everything the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [31:0] e_i;
      logic [31:0] e_pc;
      logic [31:0] e_ext;
      chk("mon_count", 64'(count), 64'(mdl_cnt));
      chk("mon_out_valid", 64'(out_valid), 64'(mdl_cnt != 0));
      chk("mon_in_ready", 64'(in_ready), 64'(mdl_cnt < DEPTH));
      if (exp_q.size() > 0) begin
        e_i  = exp_q[0][31:0];
        e_pc = exp_q[0][63:32];
      end else begin
        e_i  = 32'h0;
        e_pc = 32'h0;
      end
      if (e_i[31:26] == 6'h0C || e_i[31:26] == 6'h0D || e_i[31:26] == 6'h0E)
        e_ext = {16'h0000, e_i[15:0]};
      else
        e_ext = 32'($signed(e_i[15:0]));
      chk("mon_out_instr", 64'(out_instr), 64'(e_i));
      chk("mon_out_pc", 64'(out_pc), 64'(e_pc));
      chk("mon_fields", {opcode, rs, rt, rd, shamt, funct, imm16, target},
          {e_i[31:26], e_i[25:21], e_i[20:16], e_i[15:11], e_i[10:6], e_i[5:0], e_i[15:0],
           e_i[25:0]});
      chk("mon_imm_ext", 64'(imm_ext), 64'(e_ext));
      if (out_valid && out_ready && !flush && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_pops++;
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = p;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic push_check(input logic [31:0] ins, input logic [31:0] p);
    step(1'b1, ins, p, 1'b0, 1'b0);
    chk("push_valid", 64'(out_valid), 64'd1);
    chk("push_instr", 64'(out_instr), 64'(ins));
  endtask

  logic [31:0] words [5];
  int          pops_before;

  initial begin
    rst_n = 1'b0;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    rst_n = 1'b1;

    // lw $2,4($1)
    push_check(32'h8C220004, 32'h00400000);
    chk("lw_count", 64'(count), 64'd1);
    chk("lw_op", 64'(opcode), 64'h23);
    chk("lw_rs_rt", 64'({rs, rt}), 64'({5'd1, 5'd2}));
    chk("lw_imm16", 64'(imm16), 64'h0004);
    chk("lw_ext", 64'(imm_ext), 64'h00000004);
    chk("lw_pc", 64'(out_pc), 64'h00400000);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    push_check(32'h2021FFFF, 32'h4);
    chk("addi_ext", 64'(imm_ext), 64'hFFFFFFFF);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    push_check(32'h3421FFFF, 32'h8);
    chk("ori_ext", 64'(imm_ext), 64'h0000FFFF);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    push_check(32'h00221820, 32'hC);
    chk("add_rd", 64'(rd), 64'd3);
    chk("add_shamt", 64'(shamt), 64'd0);
    chk("add_funct", 64'(funct), 64'h20);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    push_check(32'h08100004, 32'h10);
    chk("j_target", 64'(target), 64'h0100004);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill past capacity, then drain.
    for (int i = 0; i < 5; i++) begin
      words[i] = $urandom;
      step(1'b1, words[i], 32'(i * 4), 1'b0, 1'b0);
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_count", 64'(count), 64'(4 - i));
      chk("drain_instr", 64'(out_instr), 64'(words[i]));
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    chk("drained_valid", 64'(out_valid), 64'd0);
    chk("drained_instr", 64'(out_instr), 64'd0);
    chk("drained_count", 64'(count), 64'd0);

    // Streaming with wrap.
    pops_before = n_pops;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 32'(i * 4), 1'b1, 1'b0);
      chk("stream_count", 64'(count), 64'd1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("stream_pops", 64'(n_pops - pops_before), 64'd10);
    chk("stream_empty", 64'(count), 64'd0);

    // Flush overrides push and pop.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 32'h99, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    push_check(32'h12345678, 32'h100);
    chk("post_flush_count", 64'(count), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    step(1'b1, 32'hAAAA0001, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA0002, 32'h204, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    #1 rst_n = 1'b1;
    push_check(32'h3C01BEEF, 32'h300);
    chk("arst_push_count", 64'(count), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 2) == 0) ins[31:26] = 6'(6'h0C + $urandom_range(0, 2));
      step($urandom_range(0, 3) != 0, ins, 32'(i * 4), $urandom_range(0, 2) == 0 ? 1'b0 : 1'b1,
           $urandom_range(0, 24) == 0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("final_empty", 64'(out_valid), 64'd0);
    chk("final_scoreboard", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised successor to the single instruction register of the multicycle MIPS datapath.
- A DEPTH-entry first-word-fall-through queue of fetched instruction words, each stored with its PC.
- Decodes the head entry into MIPS fields with a selectable immediate extension.
- Sits between instruction memory fetch and the control FSM/register file, so fetch can run ahead of decode and be flushed on branches/jumps.

Parameters:
DEPTH, 4, number of queue entries; must be >= 2; need not be a power of two.
PC_WIDTH, 32, width of the stored program counter.
EXT_WIDTH, 32, width of the extended immediate output; must be >= 16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous discard of all entries
in_valid  input  1  fetch side offers in_instr/in_pc
in_ready  output  1  queue accepts a word this cycle
in_instr  input  32  fetched instruction word
in_pc  input  PC_WIDTH  address of in_instr
out_valid  output  1  head entry present
out_ready  input  1  consumer takes the head entry this cycle
out_instr  output  32  head instruction word
out_pc  output  PC_WIDTH  head PC
opcode  output  6  out_instr[31:26]
rs  output  5  out_instr[25:21]
rt  output  5  out_instr[20:16]
rd  output  5  out_instr[15:11]
shamt  output  5  out_instr[10:6]
funct  output  6  out_instr[5:0]
imm16  output  16  out_instr[15:0]
imm_ext  output  EXT_WIDTH  extended imm16
target  output  26  out_instr[25:0]
count  output  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Storage: DEPTH x (32 + PC_WIDTH) registers, plus a write pointer, a read pointer and a count register. Pointers wrap to 0 after DEPTH-1 by explicit compare, not by bit truncation.
- Push: occurs when in_valid && in_ready && !flush. in_ready = (count < DEPTH). There is no pass-through when full: a push in the same cycle as a pop on a full queue is refused.
- Pop: occurs when out_valid && out_ready && !flush. out_valid = (count != 0).
- Latency: a word pushed at edge N is visible on the outputs after edge N, i.e. the earliest pop is in cycle N+1. All outputs are combinational from the head entry and the count; there is no extra register stage.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Push with out_ready high on an empty queue: the word is enqueued; there is no bypass.
- Flush: at the next edge, count = 0 and both pointers = 0. Flush overrides any push or pop in the same cycle (the offered word is dropped). in_ready still reflects count during the flush cycle.
- Empty queue: out_instr, out_pc and every decoded field output are forced to 0 (deterministic for the FSM and for checking). They are not stale data.
- imm_ext:
  - Zero-extended when opcode is 0x0C (andi), 0x0D (ori) or 0x0E (xori).
  - Otherwise sign-extended from imm16[15].
  - Upper EXT_WIDTH-16 bits only.
- Reset: asynchronous on rst_n low; clears pointers and count, so out_valid=0, in_ready=1, count=0, all data outputs 0. Storage contents are not reset. Reset during operation discards all entries immediately; the first push after rst_n rises behaves as on an empty queue.
- Ordering: strict FIFO; no reordering and no duplication.
- Illegal usage (in_valid while !in_ready, out_ready while !out_valid) is a no-op, not an error.

Test Plan:
- Single push 0x8C220004 (lw $2,4($1)), pc 0x00400000, out_ready=0 -> next cycle: out_valid=1, count=1, opcode=0x23, rs=1, rt=2, imm16=0x0004, imm_ext=0x00000004, out_pc=0x00400000.
- Extension modes:
  - 0x2021FFFF (addi) -> imm_ext=0xFFFFFFFF.
  - 0x3421FFFF (ori) -> imm_ext=0x0000FFFF.
  - 0x00221820 (add) -> rd=3, shamt=0, funct=0x20.
  - 0x08100004 (j) -> target=0x0100004.
- Fill and drain with DEPTH=4, out_ready=0: push 5 words -> count=4, in_ready=0, 5th word dropped. Then out_ready=1 -> the 4 words emerge in push order over 4 cycles, count 4,3,2,1,0, out_valid=0 and outputs 0 afterwards.
- Wrap and throughput: with in_valid and out_ready held high, stream 10 words with PCs 0x0,0x4,..,0x24 -> count steady at 1 after the first cycle, all 10 popped in order, pointers wrapping twice without loss.
- Flush: queue holds 3 entries; assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, the offered word is absent; the next push appears as head after 1 cycle.
- Reset mid-operation: with 2 entries queued, pulse rst_n low between clock edges -> out_valid=0, count=0, in_ready=1 immediately (no clock required); subsequent push/pop is normal.
